// File: rtl/data_sync_tx_sched_pkg.sv
// Shared types and helpers for the source-domain transfer scheduler.
// The state encoding matches what the destination-side tooling expects.
package data_sync_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_e;

    // Returns the bit width needed to encode 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/data_sync_tx_sched_if.sv
// Requester handshake plus the bus driven toward the multi-bit synchronizer.
interface data_sync_tx_sched_if
    import data_sync_tx_sched_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int REQ_NUM   = 4
);
    localparam int IDX_W = clog2(REQ_NUM);

    logic [REQ_NUM-1:0]           req_valid;
    logic [REQ_NUM*BUS_WIDTH-1:0] req_data;
    logic [REQ_NUM-1:0]           req_grant;
    logic [BUS_WIDTH-1:0]         async_bus;
    logic                         async_bus_en;
    logic [IDX_W-1:0]             tx_src;
    logic                         busy;

    modport master (
        output req_valid, req_data,
        input  req_grant, async_bus, async_bus_en, tx_src, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_grant, async_bus, async_bus_en, tx_src, busy
    );

endinterface

// File: rtl/data_sync_tx_sched_rr_arbiter.sv
// Combinational round-robin search starting one past the last winner.
module rr_arbiter
    import data_sync_tx_sched_pkg::*;
#(
    parameter int REQ_NUM = 4,
    localparam int IDX_W  = clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IDX_W-1:0]   last,
    input  logic               advance,
    output logic [REQ_NUM-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // NOTE: every output and temporary gets a default before the search so
    // no path through the loop leaves a value unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            idx = IDX_W'((int'(last) + i) % REQ_NUM);
            if (advance && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/data_sync_tx_sched.sv
// Picks one requester at a time and presents its word on a registered bus with
// an enable pulse of HOLD_CYCLES followed by GAP_CYCLES of quiet.
module data_sync_tx_sched
    import data_sync_tx_sched_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int REQ_NUM     = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input logic                CLK,
    input logic                RST,
    data_sync_tx_sched_if.slave bus
);

    localparam int IDX_W = clog2(REQ_NUM);
    localparam int CNT_W = clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_e               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 en_q, en_n;
    logic [BUS_WIDTH-1:0] bus_q;
    logic [IDX_W-1:0]     src_q;
    logic [IDX_W-1:0]     last;
    logic [REQ_NUM-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 accept;
    logic [BUS_WIDTH-1:0] words [REQ_NUM];

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            words[i] = bus.req_data[i*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    rr_arbiter #(.REQ_NUM(REQ_NUM)) u_arb (
        .req       (bus.req_valid),
        .last      (last),
        .advance   (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The arbiter only grants valid requesters while idle, so any grant is a transfer.
    assign accept           = |grant;
    assign bus.req_grant    = grant;
    assign bus.async_bus    = bus_q;
    assign bus.async_bus_en = en_q;
    assign bus.tx_src       = src_q;
    assign bus.busy         = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        en_n    = en_q;
        unique case (state)
            IDLE: if (accept) begin
                state_n = HOLD;
                cnt_n   = HOLD_LOAD;
                en_n    = 1'b1;
            end
            HOLD: if (cnt == '0) begin
                state_n = GAP;
                cnt_n   = GAP_LOAD;
                en_n    = 1'b0;
            end else begin
                cnt_n = cnt - 1'b1;
            end
            GAP: if (cnt == '0) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt - 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                en_n    = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            en_q  <= 1'b0;
            bus_q <= '0;
            src_q <= '0;
            last  <= IDX_W'(REQ_NUM - 1);
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            en_q  <= en_n;
            if (accept) begin
                bus_q <= words[grant_idx];
                src_q <= grant_idx;
                last  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_data_sync_tx_sched.sv
// Random and directed stimulus on two builds (4/4 and 1/1 hold/gap) checked
// against a cycle-count transaction model of the scheduler.
module tb_data_sync_tx_sched;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    data_sync_tx_sched_if #(.BUS_WIDTH(8), .REQ_NUM(4)) if0 ();
    data_sync_tx_sched_if #(.BUS_WIDTH(8), .REQ_NUM(4)) if1 ();

    data_sync_tx_sched #(.BUS_WIDTH(8), .REQ_NUM(4), .HOLD_CYCLES(4), .GAP_CYCLES(4)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (if0)
    );

    data_sync_tx_sched #(.BUS_WIDTH(8), .REQ_NUM(4), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (if1)
    );

    int n_vec = 0;
    int n_err = 0;
    int en_cnt;
    int winners[$];

    // Model: cycles elapsed since the last accepted transfer of each build.
    int        hc[2] = '{4, 1};
    int        gc[2] = '{4, 1};
    int        m_t[2];
    bit        m_act[2];
    int        m_last[2];
    logic [7:0] m_bus[2];
    int        m_src[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int k);
        return m_act[k] && (m_t[k] < hc[k] + gc[k]);
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int i = 1; i <= 4; i++) begin
            int idx;
            idx = (last + i) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_act[k] = 1'b0; m_last[k] = 3; m_bus[k] = '0; m_src[k] = 0;
        end
    endtask

    task automatic chk_outs(input int k, input logic en, input logic bsy,
                            input logic [7:0] bv, input logic [1:0] src);
        check($sformatf("en%0d", k),   en,  m_act[k] && (m_t[k] < hc[k]));
        check($sformatf("busy%0d", k), bsy, m_busy(k));
        check($sformatf("bus%0d", k),  bv,  m_bus[k]);
        check($sformatf("src%0d", k),  src, m_src[k]);
    endtask

    task automatic do_cycle(input logic [3:0] v, input logic [31:0] d);
        logic [3:0] g[2];
        int p;
        @(negedge CLK);
        if (if0.async_bus_en) en_cnt++;
        chk_outs(0, if0.async_bus_en, if0.busy, if0.async_bus, if0.tx_src);
        chk_outs(1, if1.async_bus_en, if1.busy, if1.async_bus, if1.tx_src);
        if0.req_valid = v; if0.req_data = d;
        if1.req_valid = v; if1.req_data = d;
        #1;
        g[0] = if0.req_grant;
        g[1] = if1.req_grant;
        for (int k = 0; k < 2; k++) begin
            p = m_busy(k) ? -1 : rr_pick(m_last[k], v);
            check($sformatf("grant%0d", k), g[k], (p < 0) ? 32'd0 : (32'd1 << p));
            if (p >= 0) begin
                m_bus[k] = d[p*8 +: 8]; m_src[k] = p; m_last[k] = p;
                m_act[k] = 1'b1;        m_t[k]   = 0;
            end else if (m_act[k] && m_t[k] < hc[k] + gc[k]) begin
                m_t[k]++;
            end
        end
        for (int i = 0; i < 4; i++) if (g[0][i]) winners.push_back(i);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 30 && (m_busy(0) || m_busy(1)); n++) do_cycle(4'b0000, $urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        RST = 1'b0;
        if0.req_valid = '0; if0.req_data = '0;
        if1.req_valid = '0; if1.req_data = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        chk_outs(0, if0.async_bus_en, if0.busy, if0.async_bus, if0.tx_src);
        chk_outs(1, if1.async_bus_en, if1.busy, if1.async_bus, if1.tx_src);
        RST = 1'b1;

        // Single requester 0 with A5: one 4-high enable pulse.
        en_cnt = 0;
        do_cycle(4'b0001, 32'h0000_00A5);
        repeat (11) do_cycle(4'b0000, $urandom);
        check("t1_en_high_cycles", en_cnt, 4);

        // All valid: one transfer every 9 cycles, rotating from requester 1.
        wait_idle();
        winners.delete();
        repeat (45) do_cycle(4'b1111, 32'h4433_2211);
        check("t2_transfer_count", winners.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t2_order%0d", i), (i < winners.size()) ? winners[i] : 99, (1 + i) % 4);

        // Requester 2 alone, then 1 and 3 together.
        wait_idle();
        winners.delete();
        do_cycle(4'b0100, $urandom);
        repeat (30) do_cycle(4'b1010, $urandom);
        check("t3_first",  (winners.size() > 0) ? winners[0] : 99, 2);
        check("t3_second", (winners.size() > 1) ? winners[1] : 99, 3);
        check("t3_third",  (winners.size() > 2) ? winners[2] : 99, 1);

        // Random valids, including drops by non-granted requesters while busy.
        repeat (400) do_cycle(4'($urandom_range(0, 15)), $urandom);

        // Reset during the second HOLD cycle of build 0.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            do_cycle(4'($urandom_range(1, 15)), $urandom);
            if (m_act[0] && m_t[0] == 1) found = 1'b1;
        end
        check("t5_reached_hold2", found, 1);
        @(posedge CLK);
        #2;
        check("t5_pre_rst_en", if0.async_bus_en, m_act[0] && (m_t[0] < hc[0]));
        RST = 1'b0;
        #1;
        check("t5_rst_en",   if0.async_bus_en, 0);
        check("t5_rst_bus",  if0.async_bus,    0);
        check("t5_rst_busy", if0.busy,         0);
        check("t5_rst_src",  if0.tx_src,       0);
        check("t5_rst_en1",  if1.async_bus_en, 0);
        model_reset();
        if0.req_valid = '0; if1.req_valid = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        do_cycle(4'b1010, $urandom);
        check("t5_first_grant", if0.req_grant, 4'b0010);
        repeat (40) do_cycle(4'($urandom_range(0, 15)), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
